// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: opcode/funct encodings, ALUOp codes and control-bundle types
// shared by the pipelined MIPS main control block.
package mips_ctrl_pkg;

    localparam logic [5:0] RTYPE = 6'b000000;
    localparam logic [5:0] J     = 6'b000010;
    localparam logic [5:0] BEQ   = 6'b000100;
    localparam logic [5:0] BNE   = 6'b000101;
    localparam logic [5:0] ADDI  = 6'b001000;
    localparam logic [5:0] LW    = 6'b100011;
    localparam logic [5:0] SW    = 6'b101011;

    localparam logic [5:0] MFHI  = 6'b010000;
    localparam logic [5:0] MFLO  = 6'b010010;
    localparam logic [5:0] MULT  = 6'b011000;
    localparam logic [5:0] DIV   = 6'b011010;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    typedef enum logic {MD_IDLE, MD_BUSY} md_state_e;

    typedef struct packed {
        logic [1:0] alu_op;
        logic       alu_src;
        logic       reg_dst;
    } ex_ctrl_t;

    typedef struct packed {
        logic branch;
        logic mem_read;
        logic mem_write;
    } mem_ctrl_t;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
    } wb_ctrl_t;

    typedef struct packed {
        ex_ctrl_t  ex;
        mem_ctrl_t mem;
        wb_ctrl_t  wb;
    } idex_t;

    typedef struct packed {
        mem_ctrl_t mem;
        wb_ctrl_t  wb;
    } exmem_t;

    function automatic logic is_md_op(input logic [5:0] op, input logic [5:0] fn);
        return (op == RTYPE) && ((fn == MULT) || (fn == DIV));
    endfunction

    function automatic logic is_mf_op(input logic [5:0] op, input logic [5:0] fn);
        return (op == RTYPE) && ((fn == MFHI) || (fn == MFLO));
    endfunction

endpackage

// File: rtl/mips_ctrl_pipe_md.sv
// mips_md_tracker: tracks mul/div unit occupancy, issues MULT/DIV and
// stalls HI/LO consumers while the unit is busy.
module mips_md_tracker
    import mips_ctrl_pkg::*;
#(
    parameter int MD_LATENCY = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic id_valid_i,
    input  logic is_md_i,
    input  logic is_mf_i,
    input  logic hazard_i,
    output logic md_start_o,
    output logic md_busy_o,
    output logic md_stall_o
);

    localparam logic [3:0] LOAD = 4'(MD_LATENCY - 1);

    md_state_e  state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        md_start_o = 1'b0;
        md_stall_o = 1'b0;
        if (state_q == MD_IDLE) begin
            md_start_o = id_valid_i & is_md_i & ~hazard_i;
            if (md_start_o) begin
                state_d = MD_BUSY;
                cnt_d   = LOAD;
            end
        end else begin
            md_stall_o = id_valid_i & (is_md_i | is_mf_i);
            cnt_d      = (cnt_q == '0) ? '0 : cnt_q - 4'd1;
            if (cnt_q == '0) state_d = MD_IDLE;
        end
    end

    assign md_busy_o = (state_q == MD_BUSY);

endmodule

// File: rtl/mips_ctrl_pipe.sv
// mips_ctrl_pipe: ID-stage main decoder with ID/EX, EX/MEM, MEM/WB control
// registers, load-use / mul-div stalls and branch/jump redirect.
module mips_ctrl_pipe
    import mips_ctrl_pkg::*;
#(
    parameter int ALUOP_W    = 2,
    parameter int MD_LATENCY = 4,
    parameter int EN_JUMP    = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               id_valid,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               branch_equal,
    input  logic               hazard_detected,
    output logic [ALUOP_W+1:0] ex_ctrl,
    output logic [2:0]         mem_ctrl,
    output logic [1:0]         wb_ctrl,
    output logic               pc_write,
    output logic               ifid_write,
    output logic               IF_Flush,
    output logic               pc_redirect,
    output logic               md_start,
    output logic               md_busy
);

    logic     vld, is_md, is_mf, md_stall, stall, taken, redirect;
    idex_t    dec, idex_d, idex_q;
    exmem_t   exmem_q;
    wb_ctrl_t memwb_q;

    // Reset also masks the ID inputs so every combinational output is quiet in reset.
    assign vld   = id_valid & rst_n;
    assign is_md = is_md_op(opcode, funct);
    assign is_mf = is_mf_op(opcode, funct);

    mips_md_tracker #(.MD_LATENCY(MD_LATENCY)) u_md (
        .clk        (clk),
        .rst_n      (rst_n),
        .id_valid_i (vld),
        .is_md_i    (is_md),
        .is_mf_i    (is_mf),
        .hazard_i   (hazard_detected),
        .md_start_o (md_start),
        .md_busy_o  (md_busy),
        .md_stall_o (md_stall)
    );

    always_comb begin
        dec = '0;
        case (opcode)
            LW: begin
                dec.ex.alu_src    = 1'b1;
                dec.mem.mem_read  = 1'b1;
                dec.wb.reg_write  = 1'b1;
                dec.wb.mem_to_reg = 1'b1;
            end
            SW: begin
                dec.ex.alu_src    = 1'b1;
                dec.mem.mem_write = 1'b1;
            end
            ADDI: begin
                dec.ex.alu_op    = ALU_ADD;
                dec.ex.alu_src   = 1'b1;
                dec.wb.reg_write = 1'b1;
            end
            BEQ, BNE: begin
                dec.ex.alu_op  = ALU_SUB;
                dec.mem.branch = 1'b1;
            end
            RTYPE: begin
                dec.ex.alu_op    = ALU_FUNCT;
                dec.ex.reg_dst   = 1'b1;
                dec.wb.reg_write = ~is_md;
            end
            default: ;
        endcase
    end

    assign stall    = vld & (hazard_detected | md_stall);
    assign taken    = ((opcode == BEQ) & branch_equal) | ((opcode == BNE) & ~branch_equal)
                    | ((opcode == J) & (EN_JUMP != 0));
    assign redirect = vld & ~stall & taken;
    assign idex_d   = (vld & ~stall) ? dec : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_q  <= '0;
            exmem_q <= '0;
            memwb_q <= '0;
        end else begin
            idex_q  <= idex_d;
            exmem_q <= {idex_q.mem, idex_q.wb};
            memwb_q <= exmem_q.wb;
        end
    end

    assign ex_ctrl     = {ALUOP_W'(idex_q.ex.alu_op), idex_q.ex.alu_src, idex_q.ex.reg_dst};
    assign mem_ctrl    = exmem_q.mem;
    assign wb_ctrl     = memwb_q;
    assign pc_write    = ~stall;
    assign ifid_write  = ~stall;
    assign IF_Flush    = redirect;
    assign pc_redirect = redirect;

endmodule

// File: tb/tb_mips_ctrl_pipe.sv
// tb_mips_ctrl_pipe: directed test-plan sequences plus random instruction
// streams, checked against a cycle-indexed behavioural model of the control block.
module tb_mips_ctrl_pipe;

    localparam int MD_LAT = 4;
    localparam logic [5:0] OP_R = 6'b000000, OP_J = 6'b000010, OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BNE = 6'b000101, OP_ADDI = 6'b001000, OP_LW = 6'b100011;
    localparam logic [5:0] OP_SW = 6'b101011, OP_BAD = 6'b111111;
    localparam logic [5:0] FN_ADD = 6'b100000, FN_MFHI = 6'b010000, FN_MFLO = 6'b010010;
    localparam logic [5:0] FN_MULT = 6'b011000, FN_DIV = 6'b011010;

    logic       clk = 1'b0, rst_n = 1'b0, id_valid = 1'b0;
    logic       branch_equal = 1'b0, hazard_detected = 1'b0;
    logic [5:0] opcode = '0, funct = '0;
    logic [3:0] ex_ctrl;
    logic [2:0] mem_ctrl;
    logic [1:0] wb_ctrl;
    logic       pc_write, ifid_write, IF_Flush, pc_redirect, md_start, md_busy;

    int checks = 0, fails = 0, cyc = 0, busy_end = -1;
    // Model control words {ALUOp[1:0], ALUSrc, RegDst, Branch, MemRead, MemWrite, RegWrite, MemtoReg}
    logic [8:0] p_ex = '0, p_mem = '0, p_wb = '0;
    logic [5:0] rop, rfn;

    always #5 clk = ~clk;

    mips_ctrl_pipe #(.ALUOP_W(2), .MD_LATENCY(MD_LAT), .EN_JUMP(1)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .id_valid        (id_valid),
        .opcode          (opcode),
        .funct           (funct),
        .branch_equal    (branch_equal),
        .hazard_detected (hazard_detected),
        .ex_ctrl         (ex_ctrl),
        .mem_ctrl        (mem_ctrl),
        .wb_ctrl         (wb_ctrl),
        .pc_write        (pc_write),
        .ifid_write      (ifid_write),
        .IF_Flush        (IF_Flush),
        .pc_redirect     (pc_redirect),
        .md_start        (md_start),
        .md_busy         (md_busy)
    );

    function automatic logic [8:0] dec(input logic [5:0] op, input logic [5:0] fn);
        if (op == OP_LW)   return 9'b00_10_010_11;
        if (op == OP_SW)   return 9'b00_10_001_00;
        if (op == OP_ADDI) return 9'b00_10_000_10;
        if (op == OP_BEQ || op == OP_BNE) return 9'b01_00_100_00;
        if (op == OP_R)    return (fn == FN_MULT || fn == FN_DIV) ? 9'b10_01_000_00 : 9'b10_01_000_10;
        return 9'b0;
    endfunction

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic cycle(input logic v, input logic [5:0] op, input logic [5:0] fn,
                         input logic be, input logic hz);
        logic md, mf, busy, st, start, redir;
        @(negedge clk);
        id_valid = v; opcode = op; funct = fn; branch_equal = be; hazard_detected = hz;
        #1;
        md    = (op == OP_R) && (fn == FN_MULT || fn == FN_DIV);
        mf    = (op == OP_R) && (fn == FN_MFHI || fn == FN_MFLO);
        busy  = (cyc <= busy_end);
        st    = v && (hz || (busy && (md || mf)));
        start = v && !busy && md && !hz;
        redir = v && !st && ((op == OP_BEQ && be) || (op == OP_BNE && !be) || op == OP_J);
        chk("pc_write",    9'(pc_write),    9'(!st));
        chk("ifid_write",  9'(ifid_write),  9'(!st));
        chk("IF_Flush",    9'(IF_Flush),    9'(redir));
        chk("pc_redirect", 9'(pc_redirect), 9'(redir));
        chk("md_start",    9'(md_start),    9'(start));
        chk("md_busy",     9'(md_busy),     9'(busy));
        chk("ex_ctrl",     9'(ex_ctrl),     9'(p_ex[8:5]));
        chk("mem_ctrl",    9'(mem_ctrl),    9'(p_mem[4:2]));
        chk("wb_ctrl",     9'(wb_ctrl),     9'(p_wb[1:0]));
        @(posedge clk);
        p_wb  = p_mem;
        p_mem = p_ex;
        p_ex  = (v && !st) ? dec(op, fn) : 9'b0;
        if (start) busy_end = cyc + MD_LAT;
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        id_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("rst_md_busy",    9'(md_busy),     9'd0);
        chk("rst_md_start",   9'(md_start),    9'd0);
        chk("rst_ex_ctrl",    9'(ex_ctrl),     9'd0);
        chk("rst_mem_ctrl",   9'(mem_ctrl),    9'd0);
        chk("rst_wb_ctrl",    9'(wb_ctrl),     9'd0);
        chk("rst_pc_write",   9'(pc_write),    9'd1);
        chk("rst_ifid_write", 9'(ifid_write),  9'd1);
        chk("rst_flush",      9'(IF_Flush),    9'd0);
        chk("rst_redirect",   9'(pc_redirect), 9'd0);
        p_ex = '0; p_mem = '0; p_wb = '0;
        busy_end = -1;
        @(negedge clk);
        rst_n = 1'b1;
        cyc += 2;
    endtask

    initial begin
        do_reset();
        // LW through the whole pipe
        cycle(1, OP_LW, 0, 0, 0);
        repeat (3) cycle(0, OP_BAD, 0, 0, 0);
        // load-use stall then dependent ADD
        cycle(1, OP_LW, 0, 0, 0);
        cycle(1, OP_R, FN_ADD, 0, 1);
        cycle(1, OP_R, FN_ADD, 0, 0);
        repeat (3) cycle(0, OP_R, 0, 0, 0);
        // branches and jump
        cycle(1, OP_BEQ, 0, 1, 0);
        cycle(1, OP_BNE, 0, 1, 0);
        cycle(1, OP_BNE, 0, 0, 0);
        cycle(1, OP_BEQ, 0, 0, 0);
        cycle(1, OP_J, 0, 0, 0);
        cycle(1, OP_BEQ, 0, 1, 1);
        cycle(1, OP_BEQ, 0, 1, 0);
        cycle(1, OP_SW, 0, 0, 0);
        cycle(1, OP_ADDI, 0, 0, 0);
        cycle(1, OP_BAD, 6'h2a, 1, 0);
        repeat (3) cycle(0, OP_R, 0, 0, 0);
        // MULT then MFLO stalls for the whole latency
        cycle(1, OP_R, FN_MULT, 0, 0);
        repeat (MD_LAT + 1) cycle(1, OP_R, FN_MFLO, 0, 0);
        repeat (3) cycle(0, OP_R, 0, 0, 0);
        // MULT, independent ADD, then DIV waits for IDLE
        cycle(1, OP_R, FN_MULT, 0, 0);
        cycle(1, OP_R, FN_ADD, 0, 0);
        repeat (MD_LAT) cycle(1, OP_R, FN_DIV, 0, 0);
        repeat (MD_LAT + 2) cycle(0, OP_R, 0, 0, 0);
        // hazard and mul/div stall together produce a single stall
        cycle(1, OP_R, FN_MULT, 0, 0);
        cycle(1, OP_R, FN_MFHI, 0, 1);
        repeat (MD_LAT) cycle(1, OP_R, FN_MFHI, 0, 0);
        repeat (3) cycle(0, OP_R, 0, 0, 0);
        // reset while BUSY with counter at 2, then a fresh MULT
        cycle(1, OP_R, FN_MULT, 0, 0);
        cycle(1, OP_R, FN_ADD, 0, 0);
        do_reset();
        cycle(1, OP_R, FN_MULT, 0, 0);
        repeat (MD_LAT + 2) cycle(0, OP_R, 0, 0, 0);
        // random instruction stream
        repeat (400) begin
            rfn = FN_ADD;
            case ($urandom_range(0, 10))
                0: rop = OP_LW;
                1: rop = OP_SW;
                2: rop = OP_ADDI;
                3: rop = OP_BEQ;
                4: rop = OP_BNE;
                5: rop = OP_J;
                6: rop = OP_R;
                7: begin rop = OP_R; rfn = FN_MULT; end
                8: begin rop = OP_R; rfn = FN_DIV; end
                9: begin rop = OP_R; rfn = ($urandom_range(0, 1) == 0) ? FN_MFHI : FN_MFLO; end
                default: begin rop = 6'($urandom); rfn = 6'($urandom); end
            endcase
            cycle($urandom_range(0, 99) < 85, rop, rfn, 1'($urandom), $urandom_range(0, 99) < 20);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
